// File: rtl/xor_gate_struct.sv
// Structural XOR gate with a registered statistics path:
// registered copy, running parity, rise pulse and saturating ones counter.
module xor_gate_struct #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  output logic             y,
  output logic             y_q,
  output logic             par,
  output logic             y_rise,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             ones_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic na;
  logic nb;
  logic t_anb;
  logic t_nab;

  not u_na  (na, a);
  not u_nb  (nb, b);
  and u_anb (t_anb, a, nb);
  and u_nab (t_nab, na, b);
  or  u_y   (y, t_anb, t_nab);

  logic             yreg_q, yreg_d;
  logic             par_q,  par_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             sat;

  assign sat = (cnt_q == CNT_MAX);

  // Next-state for the capture path; everything holds unless enabled.
  always_comb begin
    yreg_d = yreg_q;
    par_d  = par_q;
    cnt_d  = cnt_q;
    rise_d = en & y & ~yreg_q;
    if (en) begin
      yreg_d = y;
      par_d  = par_q ^ y;
      if (y && !sat) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      yreg_q <= 1'b0;
      par_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      yreg_q <= yreg_d;
      par_q  <= par_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_q      = yreg_q;
  assign par      = par_q;
  assign y_rise   = rise_q;
  assign ones_cnt = cnt_q;
  assign ones_sat = sat;

endmodule

// File: tb/tb_xor_gate_struct.sv
// Bench for xor_gate_struct: directed steps plus random
// stream against a behavioural model, two counter widths.
module tb_xor_gate_struct;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic en = 1'b0;

  logic       y8, yq8, par8, rise8, sat8;
  logic [7:0] cnt8;
  logic       y2, yq2, par2, rise2, sat2;
  logic [1:0] cnt2;

  int n_assert = 0;
  int n_fail = 0;

  int m_yq, m_par, m_rise, m_cnt8, m_cnt2;

  always #5 clk = clk_run ? ~clk : clk;

  xor_gate_struct #(.CNT_W(8)) u_d8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y8), .y_q(yq8), .par(par8), .y_rise(rise8),
    .ones_cnt(cnt8), .ones_sat(sat8)
  );

  xor_gate_struct #(.CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y2), .y_q(yq2), .par(par2), .y_rise(rise2),
    .ones_cnt(cnt2), .ones_sat(sat2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("y_q8", {31'd0, yq8}, m_yq);
    chk("par8", {31'd0, par8}, m_par);
    chk("rise8", {31'd0, rise8}, m_rise);
    chk("cnt8", {24'd0, cnt8}, m_cnt8);
    chk("sat8", {31'd0, sat8}, (m_cnt8 == 255) ? 1 : 0);
    chk("y_q2", {31'd0, yq2}, m_yq);
    chk("par2", {31'd0, par2}, m_par);
    chk("rise2", {31'd0, rise2}, m_rise);
    chk("cnt2", {30'd0, cnt2}, m_cnt2);
    chk("sat2", {31'd0, sat2}, (m_cnt2 == 3) ? 1 : 0);
  endtask

  // Apply inputs, check y, clock once, advance model, check all.
  task automatic step(input logic r, input logic e,
                      input logic ai, input logic bi);
    int yv;
    rst = r; en = e; a = ai; b = bi;
    yv = (ai != bi) ? 1 : 0;
    #1;
    chk("y8", {31'd0, y8}, yv);
    chk("y2", {31'd0, y2}, yv);
    @(posedge clk);
    if (r) begin
      m_yq = 0; m_par = 0; m_rise = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (e) begin
      m_rise = (yv == 1 && m_yq == 0) ? 1 : 0;
      m_yq = yv;
      m_par = (m_par + yv) % 2;
      if (yv == 1 && m_cnt8 < 255) m_cnt8++;
      if (yv == 1 && m_cnt2 < 3) m_cnt2++;
    end else begin
      m_rise = 0;
    end
    #1;
    chk_all();
  endtask

  initial begin
    int exp_yq[4]   = '{1, 0, 1, 1};
    int exp_par[4]  = '{1, 1, 0, 1};
    int exp_cnt[4]  = '{1, 1, 2, 3};
    int exp_rise[4] = '{1, 0, 1, 0};
    int sat_cnt[6]  = '{1, 2, 3, 3, 3, 3};
    logic [1:0] ab;

    m_yq = 0; m_par = 0; m_rise = 0; m_cnt8 = 0; m_cnt2 = 0;

    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a = ab[1]; b = ab[0];
      #10;
      chk("tt_y8", {31'd0, y8}, (ab == 2'b01 || ab == 2'b10) ? 1 : 0);
      chk("tt_y2", {31'd0, y2}, (ab == 2'b01 || ab == 2'b10) ? 1 : 0);
    end

    clk_run = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      ab = (i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'b10;
      step(0, 1, ab[1], ab[0]);
      chk("s_yq", {31'd0, yq8}, exp_yq[i]);
      chk("s_par", {31'd0, par8}, exp_par[i]);
      chk("s_cnt", {24'd0, cnt8}, exp_cnt[i]);
      chk("s_rise", {31'd0, rise8}, exp_rise[i]);
    end

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      chk("h_cnt", {24'd0, cnt8}, 3);
      chk("h_yq", {31'd0, yq8}, 1);
      chk("h_par", {31'd0, par8}, 1);
      chk("h_rise", {31'd0, rise8}, 0);
      chk("h_y", {31'd0, y8}, 1);
    end

    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0);
      chk("sat_cnt", {30'd0, cnt2}, sat_cnt[i]);
      chk("sat_flag", {31'd0, sat2}, (i >= 2) ? 1 : 0);
    end

    step(0, 1, 0, 1);
    rst = 1; en = 1; a = 0; b = 1;
    #1;
    chk("mr_y", {31'd0, y8}, 1);
    step(1, 1, 0, 1);
    chk("mr_yq", {31'd0, yq8}, 0);
    chk("mr_par", {31'd0, par8}, 0);
    chk("mr_cnt", {24'd0, cnt8}, 0);
    chk("mr_rise", {31'd0, rise8}, 0);

    for (int i = 0; i < 1200; i++) begin
      logic r, e, ai, bi;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ai = ($urandom_range(0, 3) != 0);
      bi = ($urandom_range(0, 3) == 0);
      step(r, e, ai, bi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_gate_struct.md
XOR_GATE_STRUCT -- requirements
Module: xor_gate_struct

Interface
- Parameters:
  - REQ-001: CNT_W, default 8: width of the ones counter, legal range 2..32.
- Ports:
  - REQ-002: clk  input  1  single clock; all sequential logic updates on its rising edge only.
  - REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
  - REQ-004: a  input  1  XOR operand A.
  - REQ-005: b  input  1  XOR operand B.
  - REQ-006: en  input  1  capture enable for the registered/statistics path.
  - REQ-007: y  output  1  combinational a XOR b.
  - REQ-008: y_q  output  1  registered copy of y.
  - REQ-009: par  output  1  running parity: XOR of all enabled y samples since reset.
  - REQ-010: y_rise  output  1  one-cycle pulse when the registered y goes 0->1.
  - REQ-011: ones_cnt  output  CNT_W  saturating count of enabled cycles with y=1.
  - REQ-012: ones_sat  output  1  high while ones_cnt equals its all-ones maximum.

Function
- REQ-013: y SHALL equal a XOR b at all times, built structurally from AND/OR/NOT gate primitives.
  - Form: y = (a AND NOT b) OR (NOT a AND b).
  - No dependence on clk, rst or en; y is valid with clk idle and rst/en unconnected.
- REQ-014: Truth table for y SHALL be 00->0, 01->1, 10->1, 11->0.
  - No X on y when a and b are known.
  - Propagation is zero-delay in simulation.
- REQ-015: On a rising clk edge with rst=0 and en=1:
  - y_q <= y
  - par <= par XOR y
  - ones_cnt <= ones_cnt+1 when y=1 and not saturated.
- REQ-016: On a rising clk edge with rst=0 and en=0, y_q, par and ones_cnt SHALL hold.
- REQ-017: ones_cnt SHALL saturate at 2^CNT_W-1 and never wrap; ones_sat = (ones_cnt == 2^CNT_W-1), combinational from the register.
- REQ-018: y_rise SHALL be registered and equal 1 for exactly the cycle after y_q changes 0->1.
  - Computed as: next y_rise = en AND y AND NOT y_q.
  - y_rise <= 0 whenever en=0.
- REQ-019: Registered-path latency SHALL be one clock: stimulus held before edge N appears on y_q/par/ones_cnt after edge N.
- REQ-020: a or b changing between edges SHALL affect only y; registered outputs reflect the value at the sampling edge.

Reset
- REQ-021: When rst=1 at a rising clk edge:
  - y_q, par, y_rise <= 0
  - ones_cnt <= 0
  - ones_sat therefore 0
- REQ-022: Reset SHALL take priority over en.
- REQ-023: Reset SHALL NOT affect y, which keeps tracking a XOR b during reset.
- REQ-024: Reset asserted mid-operation SHALL clear all registered state at that edge, discarding any in-progress count or parity.
- REQ-025: With no reset ever applied, registered outputs are unspecified; y remains fully defined.

Verification
- REQ-026: Exhaustive truth table, no clock running, 10 ns per step.
  - Stimulus: a,b = 00, 01, 10, 11.
  - Required y: 0, 1, 1, 0.
- REQ-027: Reset then stream.
  - Stimulus: rst 2 cycles; then en=1 with (a,b) = 01, 11, 10, 10.
  - Required y_q after each edge: 1, 0, 1, 1.
  - Required par: 1, 1, 0, 1.
  - Required ones_cnt: 1, 1, 2, 3.
  - Required y_rise: 1, 0, 1, 0.
- REQ-028: Enable hold.
  - Stimulus: after ones_cnt=3, set en=0 and drive a=1,b=0 for 5 cycles.
  - Required: ones_cnt stays 3; y_q and par unchanged; y_rise=0; y=1 throughout.
- REQ-029: Saturation with CNT_W=2.
  - Stimulus: en=1, a=1, b=0 for 6 cycles.
  - Required: ones_cnt 1, 2, 3, 3, 3, 3; ones_sat=1 from the third cycle on.
- REQ-030: Reset mid-stream.
  - Stimulus: rst=1 and en=1 together, with a=0, b=1.
  - Required after that edge: y_q=0, par=0, ones_cnt=0, y_rise=0.
  - Required during reset: y=1.
